// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule expander: one 512-bit block in, W[0..NUM_WORDS-1] out over a valid/ready handshake.
// Define MSG_SCHED_KADD_EN to present W[t]+K[t] on w_out instead of the raw schedule word.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; no word presented
// S_RUN  | presenting W[t] from win_q[0]; window slides on each handshake
// S_DONE | one-cycle done pulse after the final handshake
module sha256_msg_schedule #(
    parameter int NUM_WORDS = 64
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [511:0] block_in,
    output logic         busy,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [5:0]   w_index,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_T = 6'(NUM_WORDS - 1);

    state_t      state_q;
    logic [31:0] win_q [16];
    logic [5:0]  t_q;
    logic        busy_q;
    logic        w_valid_q;
    logic        done_q;
    logic [31:0] w_next_d;
    logic        hs;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // win_q[0] is W[t], so the word entering at win_q[15] is W[t+16].
    always_comb begin
        w_next_d = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
    end

    assign hs = w_valid_q & w_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            t_q       <= '0;
            busy_q    <= 1'b0;
            w_valid_q <= 1'b0;
            done_q    <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < 16; k++) begin
                            win_q[k] <= block_in[511 - 32*k -: 32];
                        end
                        t_q       <= '0;
                        busy_q    <= 1'b1;
                        w_valid_q <= 1'b1;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (hs) begin
                        if (t_q == LAST_T) begin
                            w_valid_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            for (int k = 0; k < 15; k++) begin
                                win_q[k] <= win_q[k + 1];
                            end
                            win_q[15] <= w_next_d;
                            t_q       <= t_q + 6'd1;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    t_q     <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MSG_SCHED_KADD_EN
    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // The window keeps raw W; the round constant is folded in only on the way out.
    assign w_out = w_valid_q ? (win_q[0] + K_ROM[t_q]) : 32'h0;
`else
    assign w_out = w_valid_q ? win_q[0] : 32'h0;
`endif

    assign busy    = busy_q;
    assign w_valid = w_valid_q;
    assign w_index = t_q;
    assign done    = done_q;

endmodule
